// File: rtl/sram_like_pkg.sv
// sram_like_pkg
//   Shared definitions for the sram-like responder: access-size codes, FSM
//   state encoding, the byte-enable helper and the stall LFSR seed.
//   No ports (package).
package sram_like_pkg;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

  localparam logic [7:0] LFSR_SEED = 8'hA5;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  // Size code 3 is treated as a full word. Misaligned halfwords are snapped
  // to their containing lane pair rather than faulting.
  function automatic logic [3:0] size_to_be(input logic [1:0] size,
                                            input logic [1:0] addr_lo);
    logic [3:0] be;
    case (size)
      SIZE_BYTE: be = 4'b0001 << addr_lo;
      SIZE_HALF: be = 4'b0011 << {addr_lo[1], 1'b0};
      default:   be = 4'b1111;
    endcase
    return be;
  endfunction

endpackage

// File: rtl/sram_like_word_ram.sv
// sram_like_word_ram
//   1R1W synchronous 32-bit word RAM with per-byte write enables. The read
//   data register is cleared by rst and otherwise holds its value until the
//   next read; the array itself is never cleared.
// Ports:
//   clk_i      clock
//   rst_i      synchronous active-high reset (read data register only)
//   rd_en_i    capture mem[rd_idx_i] into rd_data_o on this edge
//   rd_idx_i   read word index
//   rd_data_o  registered read data
//   we_i       write strobe
//   be_i       byte-lane write enables
//   wr_idx_i   write word index
//   wdata_i    lane-positioned write data
module sram_like_word_ram #(
  parameter int    ADDR_WIDTH = 10,
  parameter string INIT_FILE  = ""
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  rd_en_i,
  input  logic [ADDR_WIDTH-1:0] rd_idx_i,
  output logic [31:0]           rd_data_o,
  input  logic                  we_i,
  input  logic [3:0]            be_i,
  input  logic [ADDR_WIDTH-1:0] wr_idx_i,
  input  logic [31:0]           wdata_i
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [31:0] mem [DEPTH];
  logic [31:0] rd_data_q;

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      for (int b = 0; b < 4; b++) begin
        if (be_i[b]) mem[wr_idx_i][8*b +: 8] <= wdata_i[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i)        rd_data_q <= '0;
    else if (rd_en_i) rd_data_q <= mem[rd_idx_i];
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/sram_like_mem_responder.sv
// sram_like_mem_responder
//   Responder end of the sram-like req/addr_ok/data_ok interface. Accepts one
//   transaction at a time, holds it for LATENCY cycles, then completes it
//   against an internal word RAM (byte-lane writes, full-word reads).
//   Optional feature macro: SRAM_LIKE_STALL_EN -- when defined, an 8-bit
//   Fibonacci LFSR (taps 8,6,5,4) inserts pseudo-random acceptance stalls.
// Ports:
//   clk      clock, all logic on posedge
//   rst      synchronous active-high reset
//   req      initiator request
//   wr       1 = write, 0 = read
//   size     0 byte, 1 halfword, 2/3 word
//   addr     byte address (upper bits beyond the RAM alias)
//   wdata    lane-positioned write data
//   rdata    read data, valid with data_ok, held until next read completion
//   addr_ok  address accepted this cycle (combinational from req)
//   data_ok  one-cycle completion pulse
import sram_like_pkg::*;

module sram_like_mem_responder #(
  parameter int    ADDR_WIDTH = 10,
  parameter int    LATENCY    = 2,
  parameter string INIT_FILE  = ""
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        wr,
  input  logic [1:0]  size,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        addr_ok,
  output logic        data_ok
);

  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  state_e                 state_q;
  logic [3:0]             cnt_q;
  logic                   wr_q;
  logic [3:0]             be_q;
  logic [ADDR_WIDTH-1:0]  idx_q;
  logic [31:0]            wdata_q;
  logic                   data_ok_q;

  logic [ADDR_WIDTH-1:0]  idx_d;
  logic [3:0]             be_d;
  logic                   stall;
  logic                   complete;
  logic                   unused_addr;

  assign idx_d       = addr[ADDR_WIDTH+1:2];
  assign be_d        = size_to_be(size, addr[1:0]);
  assign unused_addr = ^addr[31:ADDR_WIDTH+2];

`ifdef SRAM_LIKE_STALL_EN
  logic [7:0] lfsr_q;

  always_ff @(posedge clk) begin
    if (rst) lfsr_q <= LFSR_SEED;
    else     lfsr_q <= {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
  end

  assign stall = lfsr_q[0];
`else
  assign stall = 1'b0;
`endif

  // The state is already IDLE while data_ok is high; masking with data_ok_q
  // keeps the completion cycle free of a new acceptance.
  assign addr_ok  = (state_q == IDLE) & req & ~data_ok_q & ~stall;
  assign complete = (state_q == BUSY) & (cnt_q == 4'd0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= 4'd0;
      wr_q      <= 1'b0;
      be_q      <= 4'd0;
      idx_q     <= '0;
      wdata_q   <= '0;
      data_ok_q <= 1'b0;
    end else begin
      data_ok_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (addr_ok) begin
            wr_q    <= wr;
            be_q    <= be_d;
            idx_q   <= idx_d;
            wdata_q <= wdata;
            cnt_q   <= CNT_INIT;
            state_q <= BUSY;
          end
        end
        BUSY: begin
          if (cnt_q != 4'd0) begin
            cnt_q <= cnt_q - 4'd1;
          end else begin
            data_ok_q <= 1'b1;
            state_q   <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // A reset landing on the completion edge must drop the pending write.
  sram_like_word_ram #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .INIT_FILE  (INIT_FILE)
  ) u_ram (
    .clk_i     (clk),
    .rst_i     (rst),
    .rd_en_i   (complete & ~wr_q & ~rst),
    .rd_idx_i  (idx_q),
    .rd_data_o (rdata),
    .we_i      (complete & wr_q & ~rst),
    .be_i      (be_q),
    .wr_idx_i  (idx_q),
    .wdata_i   (wdata_q)
  );

  assign data_ok = data_ok_q;

endmodule

// File: tb/tb_sram_like_mem_responder.sv
module tb_sram_like_mem_responder;

  localparam int LAT0 = 2;
  localparam int LAT1 = 1;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  logic        req = 1'b0, wr = 1'b0;
  logic [1:0]  size = 2'd0;
  logic [31:0] addr = '0, wdata = '0;
  logic [31:0] rdata;
  logic        addr_ok, data_ok;

  logic        req1 = 1'b0, wr1 = 1'b0;
  logic [1:0]  size1 = 2'd0;
  logic [31:0] addr1 = '0, wdata1 = '0;
  logic [31:0] rdata1;
  logic        addr_ok1, data_ok1;

  int total = 0;
  int bad   = 0;

  logic [31:0] model_mem [int];
  logic [31:0] last_rd = '0;

  always #5 clk = ~clk;

  sram_like_mem_responder #(.ADDR_WIDTH(10), .LATENCY(LAT0), .INIT_FILE("")) dut (
    .clk(clk), .rst(rst), .req(req), .wr(wr), .size(size), .addr(addr),
    .wdata(wdata), .rdata(rdata), .addr_ok(addr_ok), .data_ok(data_ok)
  );

  sram_like_mem_responder #(.ADDR_WIDTH(10), .LATENCY(LAT1), .INIT_FILE("")) dut1 (
    .clk(clk), .rst(rst), .req(req1), .wr(wr1), .size(size1), .addr(addr1),
    .wdata(wdata1), .rdata(rdata1), .addr_ok(addr_ok1), .data_ok(data_ok1)
  );

  // Reference model: word index wraps modulo the 1024-word RAM; a write
  // replaces the bytes named by its size and byte offset.
  function automatic int widx(input logic [31:0] a);
    return int'((a / 4) % 1024);
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                        input logic [1:0] sz, input logic [31:0] a);
    logic [31:0] r;
    int lane;
    bit hit;
    r = old;
    lane = int'(a % 4);
    for (int b = 0; b < 4; b++) begin
      if (sz == 2'd0)      hit = (b == lane);
      else if (sz == 2'd1) hit = ((b / 2) == (lane / 2));
      else                 hit = 1'b1;
      if (hit) r[8*b +: 8] = wd[8*b +: 8];
    end
    return r;
  endfunction

  task automatic wait_accept(output bit acc, output int stalls);
    acc = 1'b0;
    stalls = 0;
    for (int t = 0; t < 100 && !acc; t++) begin
      #1;
      acc = addr_ok;
      if (!acc) stalls++;
      @(posedge clk);
      if (!acc) @(negedge clk);
    end
  endtask

  // lat = edges from the accepting edge to the edge raising data_ok;
  // -2 if never accepted, -1 if never completed.
  task automatic do_txn(input bit w, input logic [1:0] sz, input logic [31:0] a,
                        input logic [31:0] d, output int lat, output logic [31:0] rd,
                        output int stalls);
    bit acc;
    int k;
    lat = -1;
    rd = '0;
    k = 0;
    @(negedge clk);
    req = 1'b1; wr = w; size = sz; addr = a; wdata = d;
    wait_accept(acc, stalls);
    if (!acc) begin
      req = 1'b0;
      lat = -2;
      return;
    end
    for (int t = 1; t <= 40 && k == 0; t++) begin
      @(negedge clk);
      if (t == 1) begin
        req = 1'b0;
        wr = 1'($urandom_range(0, 1));
        size = 2'($urandom_range(0, 3));
        addr = $urandom;
        wdata = $urandom;
      end
      if (data_ok) begin
        k = t;
        rd = rdata;
      end
    end
    if (k != 0) lat = k - 1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    total++; if (data_ok !== 1'b0) begin bad++; $display("FAIL reset_data_ok: got %b want 0", data_ok); end
    total++; if (rdata !== 32'h0) begin bad++; $display("FAIL reset_rdata: got %h want 00000000", rdata); end
    total++; if (addr_ok !== 1'b0) begin bad++; $display("FAIL reset_addr_ok_noreq: got %b want 0", addr_ok); end
    total++; if (data_ok1 !== 1'b0) begin bad++; $display("FAIL reset_data_ok1: got %b want 0", data_ok1); end
`ifndef SRAM_LIKE_STALL_EN
    req = 1'b1;
    #1;
    total++; if (addr_ok !== 1'b1) begin bad++; $display("FAIL reset_addr_ok_req: got %b want 1", addr_ok); end
    req = 1'b0;
`endif
    @(negedge clk);
    rst = 1'b0;
    last_rd = '0;
  endtask

  task automatic test_read_basic();
    int lat, st;
    logic [31:0] rd;
    do_txn(1'b1, 2'd2, 32'h14, 32'hDEADBEEF, lat, rd, st);
    model_mem[widx(32'h14)] = 32'hDEADBEEF;
    total++; if (lat !== LAT0) begin bad++; $display("FAIL basic_wr_lat: got %0d want %0d", lat, LAT0); end
    do_txn(1'b0, 2'd2, 32'h14, 32'h0, lat, rd, st);
    total++; if (lat !== LAT0) begin bad++; $display("FAIL basic_rd_lat: got %0d want %0d", lat, LAT0); end
    total++; if (rd !== 32'hDEADBEEF) begin bad++; $display("FAIL basic_rd_data: got %h want deadbeef", rd); end
`ifndef SRAM_LIKE_STALL_EN
    total++; if (st !== 0) begin bad++; $display("FAIL basic_addr_ok_same_cycle: got %0d stalls want 0", st); end
`endif
    last_rd = 32'hDEADBEEF;
  endtask

  task automatic test_byte_write();
    int lat, st;
    logic [31:0] rd;
    do_txn(1'b1, 2'd2, 32'h100, 32'h11223344, lat, rd, st);
    do_txn(1'b1, 2'd0, 32'h103, 32'hAB000000, lat, rd, st);
    model_mem[widx(32'h100)] = merge(32'h11223344, 32'hAB000000, 2'd0, 32'h103);
    total++; if (rd !== last_rd) begin bad++; $display("FAIL byte_wr_rdata_hold: got %h want %h", rd, last_rd); end
    do_txn(1'b0, 2'd2, 32'h100, 32'h0, lat, rd, st);
    total++; if (rd !== 32'hAB223344) begin bad++; $display("FAIL byte_wr_readback: got %h want ab223344", rd); end
    total++; if (rd !== model_mem[widx(32'h100)]) begin bad++; $display("FAIL byte_wr_model: got %h want %h", rd, model_mem[widx(32'h100)]); end
    last_rd = 32'hAB223344;
  endtask

  task automatic test_half_alias();
    int lat, st;
    logic [31:0] rd;
    do_txn(1'b1, 2'd2, 32'h0, 32'h12347788, lat, rd, st);
    do_txn(1'b1, 2'd1, 32'h1002, 32'h55660000, lat, rd, st);
    model_mem[widx(32'h0)] = merge(32'h12347788, 32'h55660000, 2'd1, 32'h1002);
    do_txn(1'b0, 2'd2, 32'h0, 32'h0, lat, rd, st);
    total++; if (rd !== 32'h55667788) begin bad++; $display("FAIL half_alias_readback: got %h want 55667788", rd); end
    total++; if (lat !== LAT0) begin bad++; $display("FAIL half_alias_lat: got %0d want %0d", lat, LAT0); end
    last_rd = rd;
  endtask

  task automatic test_random();
    int lat, st, idx, lane;
    logic [31:0] a, d, rd, exp;
    bit w;
    logic [1:0] sz;
    for (int i = 0; i < 16; i++) begin
      a = ($urandom & 32'hFFFF_F000) | (32'(i) * 4);
      d = $urandom;
      do_txn(1'b1, 2'd2, a, d, lat, rd, st);
      model_mem[widx(a)] = d;
      total++; if (lat !== LAT0) begin bad++; $display("FAIL rand_preload_lat: got %0d want %0d", lat, LAT0); end
    end
    for (int i = 0; i < 60; i++) begin
      w = 1'($urandom_range(0, 1));
      sz = 2'($urandom_range(0, 3));
      idx = $urandom_range(0, 15);
      lane = $urandom_range(0, 3);
      a = ($urandom & 32'hFFFF_F000) | 32'(idx * 4 + lane);
      d = $urandom;
      do_txn(w, sz, a, d, lat, rd, st);
      total++; if (lat !== LAT0) begin bad++; $display("FAIL rand_lat: op %0d got %0d want %0d", i, lat, LAT0); end
      if (w) begin
        model_mem[widx(a)] = merge(model_mem[widx(a)], d, sz, a);
        total++; if (rd !== last_rd) begin bad++; $display("FAIL rand_wr_rdata_hold: op %0d got %h want %h", i, rd, last_rd); end
      end else begin
        exp = model_mem[widx(a)];
        total++; if (rd !== exp) begin bad++; $display("FAIL rand_rd_data: op %0d addr %h got %h want %h", i, a, rd, exp); end
        last_rd = exp;
      end
    end
  endtask

  task automatic test_back_to_back();
    bit ao [12];
    bit exp_do;
    int n_ao, n_do10;
    n_ao = 0;
    n_do10 = 0;
    @(negedge clk);
    req1 = 1'b1; wr1 = 1'b1; size1 = 2'd2; addr1 = 32'h40; wdata1 = $urandom;
    for (int i = 0; i < 12; i++) begin
      if (i == 10) req1 = 1'b0;
      #1;
      ao[i] = addr_ok1;
      if (addr_ok1) n_ao++;
      if (data_ok1 && i < 10) n_do10++;
      exp_do = (i >= LAT1 + 1) ? ao[i - LAT1 - 1] : 1'b0;
      total++; if (data_ok1 !== exp_do) begin bad++; $display("FAIL b2b_data_ok: cycle %0d got %b want %b", i, data_ok1, exp_do); end
      total++; if (addr_ok1 && data_ok1) begin bad++; $display("FAIL b2b_overlap: cycle %0d got addr_ok=1 data_ok=1 want not both", i); end
      @(negedge clk);
    end
`ifndef SRAM_LIKE_STALL_EN
    total++; if (n_ao !== 4) begin bad++; $display("FAIL b2b_accepts: got %0d want 4", n_ao); end
    total++; if (n_do10 !== 3) begin bad++; $display("FAIL b2b_completions: got %0d want 3", n_do10); end
`endif
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset_mid_write();
    int lat, st, seen;
    logic [31:0] rd;
    bit acc;
    do_txn(1'b1, 2'd2, 32'h1C, 32'h0, lat, rd, st);
    model_mem[widx(32'h1C)] = 32'h0;
    @(negedge clk);
    req = 1'b1; wr = 1'b1; size = 2'd2; addr = 32'h1C; wdata = 32'hFFFFFFFF;
    wait_accept(acc, st);
    total++; if (!acc) begin bad++; $display("FAIL rstmid_accept: got no addr_ok want accept"); end
    req = 1'b0;
    repeat (LAT0) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    for (int i = 0; i < LAT0 + 3; i++) begin
      #1;
      if (data_ok) seen++;
      @(negedge clk);
    end
    total++; if (seen !== 0) begin bad++; $display("FAIL rstmid_no_data_ok: got %0d pulses want 0", seen); end
    total++; if (rdata !== 32'h0) begin bad++; $display("FAIL rstmid_rdata_cleared: got %h want 00000000", rdata); end
    last_rd = '0;
    do_txn(1'b0, 2'd2, 32'h1C, 32'h0, lat, rd, st);
    total++; if (rd !== 32'h0) begin bad++; $display("FAIL rstmid_write_dropped: got %h want 00000000", rd); end
    total++; if (lat !== LAT0) begin bad++; $display("FAIL rstmid_rd_lat: got %0d want %0d", lat, LAT0); end
    last_rd = 32'h0;
  endtask

`ifdef SRAM_LIKE_STALL_EN
  task automatic test_stall();
    int lat, st, cyc, sum_st, idx;
    logic [31:0] a, rd, exp;
    cyc = 0;
    sum_st = 0;
    while (cyc < 200) begin
      idx = $urandom_range(0, 15);
      a = ($urandom & 32'hFFFF_F000) | 32'(idx * 4);
      do_txn(1'b0, 2'd2, a, 32'h0, lat, rd, st);
      exp = model_mem[widx(a)];
      total++; if (lat !== LAT0) begin bad++; $display("FAIL stall_lat: got %0d want %0d", lat, LAT0); end
      total++; if (rd !== exp) begin bad++; $display("FAIL stall_rd_data: got %h want %h", rd, exp); end
      last_rd = exp;
      sum_st += st;
      cyc += st + LAT0 + 2;
    end
    total++; if (sum_st == 0) begin bad++; $display("FAIL stall_seen: got 0 stall cycles want at least 1"); end
  endtask
`else
  task automatic test_no_stall();
    int lat, st, idx;
    logic [31:0] a, rd, exp;
    for (int i = 0; i < 8; i++) begin
      idx = $urandom_range(0, 15);
      a = ($urandom & 32'hFFFF_F000) | 32'(idx * 4);
      do_txn(1'b0, 2'd3, a, 32'h0, lat, rd, st);
      exp = model_mem[widx(a)];
      total++; if (st !== 0) begin bad++; $display("FAIL nostall_accept: got %0d stalls want 0", st); end
      total++; if (rd !== exp) begin bad++; $display("FAIL nostall_rd_data: got %h want %h", rd, exp); end
      last_rd = exp;
    end
  endtask
`endif

  initial begin
    test_reset();
    test_read_basic();
    test_byte_write();
    test_half_alias();
    test_back_to_back();
    test_reset_mid_write();
    test_random();
`ifdef SRAM_LIKE_STALL_EN
    test_stall();
`else
    test_no_stall();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

endmodule
